// File: rtl/regfile_ctl_if.sv
// Byte-stream side of the regfile command sequencer: framed bytes in, shift-out byte and busy back.
interface regfile_ctl_if;
  logic       frame_en_i;
  logic       byte_vld_i;
  logic [7:0] byte_data_i;
  logic [7:0] tx_data_o;
  logic       busy_o;

  // Byte receiver / host side
  modport master (
    output frame_en_i,
    output byte_vld_i,
    output byte_data_i,
    input  tx_data_o,
    input  busy_o
  );

  // Command sequencer side
  modport slave (
    input  frame_en_i,
    input  byte_vld_i,
    input  byte_data_i,
    output tx_data_o,
    output busy_o
  );
endinterface

// File: rtl/regfile_ctl.sv
// regfile_ctl: decodes framed command bytes into 64-bit config write bursts and
// auto-incrementing read bursts toward the regfile. reg_rd_en_o is held for the
// whole read burst so the regfile shadow bytes stay frozen and coherent.
// Optional error counter (err_cnt_o) is built only when REGFILE_CTL_ERR_CNT_EN is defined.
module regfile_ctl #(
  parameter logic [7:0] CMD_WR = 8'h2A,
  parameter logic [7:0] CMD_RD = 8'h3A
`ifdef REGFILE_CTL_ERR_CNT_EN
  ,
  parameter int unsigned ERR_W = 8
`endif
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  regfile_ctl_if.slave        bus,
  output logic                reg_rd_en_o,
  output logic [3:0]          reg_rd_addr_o,
  input  logic [7:0]          reg_rd_data_i,
  output logic                reg_wr_en_o,
  output logic [63:0]         reg_wr_data_o
`ifdef REGFILE_CTL_ERR_CNT_EN
  ,
  output logic [ERR_W-1:0]    err_cnt_o
`endif
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WR_DATA,
    S_RD_ADDR,
    S_RD_DATA,
    S_DISCARD
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   wr_buf_q, wr_buf_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                byte_stb;

`ifdef REGFILE_CTL_ERR_CNT_EN
  logic                err_inc;
  logic [ERR_W-1:0]    err_q, err_d;
`endif

  assign byte_stb = bus.frame_en_i & bus.byte_vld_i;

  // Next-state and output decode; a dropped frame always wins and returns to IDLE
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_buf_d  = wr_buf_q;
    rd_en_d   = rd_en_q;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_data_d = wr_data_q;
`ifdef REGFILE_CTL_ERR_CNT_EN
    err_inc   = 1'b0;
`endif

    if (!bus.frame_en_i) begin
      state_d = S_IDLE;
      rd_en_d = 1'b0;
      // A write frame that ends before the 8th data byte is an aborted write
      if (state_q == S_WR_DATA) begin
`ifdef REGFILE_CTL_ERR_CNT_EN
        err_inc = 1'b1;
`endif
      end
    end else begin
      unique case (state_q)
        S_IDLE: state_d = S_CMD;
        S_CMD: begin
          if (byte_stb) begin
            if (bus.byte_data_i == CMD_WR) begin
              state_d  = S_WR_DATA;
              cnt_d    = '0;
              wr_buf_d = '0;
            end else if (bus.byte_data_i == CMD_RD) begin
              state_d = S_RD_ADDR;
            end else begin
              state_d = S_DISCARD;
`ifdef REGFILE_CTL_ERR_CNT_EN
              err_inc = 1'b1;
`endif
            end
          end
        end
        S_WR_DATA: begin
          if (byte_stb) begin
            wr_buf_d[{cnt_q, 3'b000} +: BYTE_W] = bus.byte_data_i;
            cnt_d = cnt_q + CNT_W'(1);
            // Last byte of the word: commit the whole assembled word in one pulse
            if (cnt_q == CNT_W'(7)) begin
              wr_en_d   = 1'b1;
              wr_data_d = wr_buf_d;
              state_d   = S_DISCARD;
            end
          end
        end
        S_RD_ADDR: begin
          if (byte_stb) begin
            rd_addr_d = bus.byte_data_i[ADDR_W-1:0];
            rd_en_d   = 1'b1;
            state_d   = S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (byte_stb) begin
            rd_addr_d = rd_addr_q + ADDR_W'(1);
          end
        end
        S_DISCARD: state_d = S_DISCARD;
        default:   state_d = S_IDLE;
      endcase
    end

`ifdef REGFILE_CTL_ERR_CNT_EN
    // Saturating error count, cleared only by reset
    err_d = err_q;
    if (err_inc && (err_q != {ERR_W{1'b1}})) begin
      err_d = err_q + ERR_W'(1);
    end
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_buf_q  <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
`ifdef REGFILE_CTL_ERR_CNT_EN
      err_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_buf_q  <= wr_buf_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
`ifdef REGFILE_CTL_ERR_CNT_EN
      err_q     <= err_d;
`endif
    end
  end

  // Read data passes straight through during a read burst so it shifts out with no added latency
  assign bus.tx_data_o = (state_q == S_RD_DATA) ? reg_rd_data_i : 8'hFF;
  assign bus.busy_o    = (state_q != S_IDLE);

  assign reg_rd_en_o   = rd_en_q;
  assign reg_rd_addr_o = rd_addr_q;
  assign reg_wr_en_o   = wr_en_q;
  assign reg_wr_data_o = wr_data_q;
`ifdef REGFILE_CTL_ERR_CNT_EN
  assign err_cnt_o     = err_q;
`endif

endmodule
